rcpu_mem_bus: RTL and testbench

//  Memory-side stage directly downstream of the RCPU memory port (memAddr/memWrite/memWE/memRead).

---
 rtl/rcpu_mem_bus_pkg.sv | 18 +
 rtl/sync_fifo.sv | 51 +++++
 rtl/rcpu_mem_bus.sv | 154 +++++++++++++++
 tb/tb_rcpu_mem_bus.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/rcpu_mem_bus_pkg.sv
// rtl/rcpu_mem_bus_pkg.sv - IO window offsets and STATUS bit layout shared by rcpu_mem_bus
package rcpu_mem_bus_pkg;

  localparam logic [3:0] IO_TXDATA = 4'd0;
  localparam logic [3:0] IO_STATUS = 4'd1;
  localparam logic [3:0] IO_RXDATA = 4'd2;
  localparam logic [3:0] IO_TIMER  = 4'd3;

  localparam int ST_TXFULL  = 0;
  localparam int ST_TXEMPTY = 1;
  localparam int ST_RXHELD  = 2;
  localparam int ST_TXOVF   = 3;
  localparam int ST_RXOVR   = 4;

  // consecutive stalled cycles before rxOvr fires is 2**STALL_W
  localparam int STALL_W = 8;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with occupancy count; contents are not reset
module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             pushData,
  input  logic                     pop,
  output logic [W-1:0]             popData,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;
  logic          doPush;
  logic          doPop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign doPush  = push & ~full;
  assign doPop   = pop & ~empty;
  assign popData = mem[rdPtr];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + AW'(1);
      if (doPop)  rdPtr <= rdPtr + AW'(1);
      case ({doPush, doPop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= pushData;
  end

endmodule

// File: rtl/rcpu_mem_bus.sv
// rtl/rcpu_mem_bus.sv - decodes RCPU memory accesses into RAM or a 16-word IO window
module rcpu_mem_bus
  import rcpu_mem_bus_pkg::*;
#(
  parameter int           M          = 16,
  parameter logic [M-1:0] IO_BASE    = 16'hFFF0,
  parameter int           FIFO_DEPTH = 8,
  parameter int           PRESCALE   = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [M-1:0] cpuAddr,
  input  logic [M-1:0] cpuWrite,
  input  logic         cpuWE,
  output logic [M-1:0] cpuRead,
  output logic [M-1:0] ramAddr,
  output logic [M-1:0] ramWData,
  output logic         ramWE,
  input  logic [M-1:0] ramRData,
  output logic [7:0]   txData,
  output logic         txValid,
  input  logic         txReady,
  input  logic [7:0]   rxData,
  input  logic         rxValid,
  output logic         rxReady
);

  localparam int CW = $clog2(FIFO_DEPTH);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic              isIO;
  logic [3:0]        off;
  logic              ioWE;
  logic              txPush;
  logic              txFull;
  logic              txEmpty;
  logic [CW:0]       txCount;
  logic              txOvf;
  logic              statWE;
  logic              rxClr;
  logic              rxHeld;
  logic [7:0]        rxHold;
  logic              rxOvr;
  logic              stalled;
  logic [STALL_W-1:0] stallCnt;
  logic              timerLoad;
  logic              tick;
  logic [PW-1:0]     prescaler;
  logic [M-1:0]      timerCount;
  logic [M-1:0]      ioRd;

  assign isIO      = (cpuAddr[M-1:4] == IO_BASE[M-1:4]);
  assign off       = cpuAddr[3:0];
  assign ioWE      = cpuWE & isIO;
  assign txPush    = ioWE && (off == IO_TXDATA);
  assign statWE    = ioWE && (off == IO_STATUS);
  assign rxClr     = ioWE && (off == IO_RXDATA);
  assign timerLoad = ioWE && (off == IO_TIMER);

  assign ramAddr  = cpuAddr;
  assign ramWData = cpuWrite;
  assign ramWE    = cpuWE & ~isIO & rst;

  // a write to a full FIFO is dropped even if the consumer pops that cycle
  sync_fifo #(.W(8), .DEPTH(FIFO_DEPTH)) u_txFifo (
    .clk      (clk),
    .rst      (rst),
    .push     (txPush),
    .pushData (cpuWrite[7:0]),
    .pop      (txValid & txReady),
    .popData  (txData),
    .full     (txFull),
    .empty    (txEmpty),
    .count    (txCount)
  );

  assign txValid = (txCount != '0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      txOvf <= 1'b0;
    end else if (txPush && txFull) begin
      txOvf <= 1'b1;
    end else if (statWE && cpuWrite[ST_TXOVF]) begin
      txOvf <= 1'b0;
    end
  end

  assign rxReady = rst & ~rxHeld;
  assign stalled = rxValid & rxHeld;

  // the clearing write wins; a waiting byte is taken on the following cycle
  always_ff @(posedge clk) begin
    if (!rst) begin
      rxHeld <= 1'b0;
      rxHold <= '0;
    end else if (rxClr) begin
      rxHeld <= 1'b0;
    end else if (rxValid && rxReady) begin
      rxHeld <= 1'b1;
      rxHold <= rxData;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stallCnt <= '0;
      rxOvr    <= 1'b0;
    end else begin
      stallCnt <= stalled ? stallCnt + STALL_W'(1) : '0;
      if (stalled && (stallCnt == '1)) begin
        rxOvr <= 1'b1;
      end else if (statWE && cpuWrite[ST_RXOVR]) begin
        rxOvr <= 1'b0;
      end
    end
  end

  assign tick = (prescaler == PW'(PRESCALE - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      prescaler  <= '0;
      timerCount <= '0;
    end else if (timerLoad) begin
      prescaler  <= '0;
      timerCount <= cpuWrite;
    end else if (tick) begin
      prescaler  <= '0;
      timerCount <= timerCount + M'(1);
    end else begin
      prescaler  <= prescaler + PW'(1);
    end
  end

  always_comb begin
    ioRd = '0;
    case (off)
      IO_STATUS: begin
        ioRd[ST_TXFULL]  = txFull;
        ioRd[ST_TXEMPTY] = txEmpty;
        ioRd[ST_RXHELD]  = rxHeld;
        ioRd[ST_TXOVF]   = txOvf;
        ioRd[ST_RXOVR]   = rxOvr;
      end
      IO_RXDATA: ioRd[7:0] = rxHold;
      IO_TIMER:  ioRd      = timerCount;
      default:   ioRd      = '0;
    endcase
  end

  assign cpuRead = isIO ? ioRd : ramRData;

endmodule

// File: tb/tb_rcpu_mem_bus.sv
// tb/tb_rcpu_mem_bus.sv - directed and random checks of rcpu_mem_bus against a queue-based model
module tb_rcpu_mem_bus;

  localparam int DEPTH = 8;
  localparam int PRE   = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] cpuAddr = '0, cpuWrite = '0, ramRData = '0;
  logic        cpuWE = 1'b0, txReady = 1'b0, rxValid = 1'b0;
  logic [7:0]  rxData = '0;
  logic [15:0] cpuRead, ramAddr, ramWData;
  logic        ramWE, txValid, rxReady;
  logic [7:0]  txData;

  rcpu_mem_bus #(.M(16), .IO_BASE(16'hFFF0), .FIFO_DEPTH(DEPTH), .PRESCALE(PRE)) dut (
    .clk(clk), .rst(rst), .cpuAddr(cpuAddr), .cpuWrite(cpuWrite), .cpuWE(cpuWE),
    .cpuRead(cpuRead), .ramAddr(ramAddr), .ramWData(ramWData), .ramWE(ramWE),
    .ramRData(ramRData), .txData(txData), .txValid(txValid), .txReady(txReady),
    .rxData(rxData), .rxValid(rxValid), .rxReady(rxReady)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chkEn  = 0;

  logic [7:0]  q[$];
  logic        mHeld = 0, mOvf = 0, mOvr = 0;
  logic [7:0]  mHold = '0;
  logic [15:0] mTime = '0;
  int          mPre = 0, mStall = 0;

  logic [15:0] obsRead;
  logic        obsRamWE, obsTxValid, obsRxReady;
  logic [7:0]  obsTxData;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] expIo(input logic [3:0] off);
    case (off)
      4'd1:    return {11'b0, mOvr, mOvf, mHeld, q.size() == 0, q.size() == DEPTH};
      4'd2:    return {8'h00, mHold};
      4'd3:    return mTime;
      default: return 16'h0000;
    endcase
  endfunction

  task automatic modelStep(input logic [15:0] a, wd, input logic we, txr, rxv, input logic [7:0] rxd);
    logic io, wasFull, wasHeld;
    logic [3:0] off;
    if (!rst) begin
      q.delete();
      mHeld = 0; mHold = '0; mTime = '0; mPre = 0; mOvf = 0; mOvr = 0; mStall = 0;
    end else begin
      io = (a[15:4] == 12'hFFF);
      off = a[3:0];
      wasFull = (q.size() == DEPTH);
      wasHeld = mHeld;
      if (q.size() != 0 && txr) void'(q.pop_front());
      if (we && io && off == 4'd0) begin
        if (wasFull) mOvf = 1; else q.push_back(wd[7:0]);
      end
      if (we && io && off == 4'd1) begin
        if (wd[3]) mOvf = 0;
        if (wd[4]) mOvr = 0;
      end
      if (rxv && wasHeld) begin
        mStall++;
        if (mStall % 256 == 0) mOvr = 1;
      end else begin
        mStall = 0;
      end
      if (we && io && off == 4'd2) mHeld = 0;
      else if (rxv && !wasHeld) begin mHold = rxd; mHeld = 1; end
      if (we && io && off == 4'd3) begin mTime = wd; mPre = 0; end
      else if (mPre == PRE - 1) begin mPre = 0; mTime = mTime + 16'd1; end
      else mPre++;
    end
  endtask

  task automatic cyc(input logic [15:0] a, wd, input logic we, txr, rxv, input logic [7:0] rxd);
    logic io;
    cpuAddr = a; cpuWrite = wd; cpuWE = we; txReady = txr; rxValid = rxv; rxData = rxd;
    ramRData = 16'($urandom);
    #1;
    obsRead = cpuRead; obsRamWE = ramWE; obsTxValid = txValid; obsTxData = txData; obsRxReady = rxReady;
    if (chkEn) begin
      io = (a[15:4] == 12'hFFF);
      chk("cpuRead", cpuRead, io ? expIo(a[3:0]) : ramRData);
      chk("ramWE", {15'b0, ramWE}, {15'b0, we & ~io & rst});
      chk("ramAddr", ramAddr, a);
      chk("ramWData", ramWData, wd);
      chk("txValid", {15'b0, txValid}, {15'b0, q.size() != 0});
      if (q.size() != 0) chk("txData", {8'h00, txData}, {8'h00, q[0]});
      chk("rxReady", {15'b0, rxReady}, {15'b0, rst & ~mHeld});
    end
    @(posedge clk); #1;
    modelStep(a, wd, we, txr, rxv, rxd);
  endtask

  task automatic rd(input logic [15:0] a);
    cyc(a, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    cyc(a, d, 1'b1, 1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    int n;
    logic [7:0] lastByte;
    logic [15:0] ra;

    rst = 0;
    cyc(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h00);
    chkEn = 1;
    cyc(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h00);
    rst = 1;

    rd(16'hFFF1);
    chk("reset_status", obsRead, 16'h0002);
    wr(16'h0010, 16'hBEEF);
    chk("ram_we", {15'b0, obsRamWE}, 16'h0001);
    wr(16'hFFF3, 16'h0000);
    chk("io_no_ram_we", {15'b0, obsRamWE}, 16'h0000);

    wr(16'hFFF0, 16'h0041);
    chk("push_empty_not_yet", {15'b0, obsTxValid}, 16'h0000);
    wr(16'hFFF0, 16'h0042);
    cyc(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("tx_head_valid", {15'b0, obsTxValid}, 16'h0001);
    chk("tx_head_data", {8'h00, obsTxData}, 16'h0041);
    cyc(16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 8'h00);
    chk("tx_pop1", {8'h00, obsTxData}, 16'h0041);
    cyc(16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 8'h00);
    chk("tx_pop2", {8'h00, obsTxData}, 16'h0042);
    cyc(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("tx_drained", {15'b0, obsTxValid}, 16'h0000);

    for (int i = 1; i <= 9; i++) wr(16'hFFF0, 16'(i));
    rd(16'hFFF1);
    chk("overflow_status", obsRead, 16'h0009);
    wr(16'hFFF1, 16'h0008);
    rd(16'hFFF1);
    chk("ovf_cleared", obsRead, 16'h0001);
    for (int i = 1; i <= 8; i++) begin
      cyc(16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 8'h00);
      chk("drain_order", {8'h00, obsTxData}, 16'(i));
    end
    rd(16'hFFF1);
    chk("drained_status", obsRead, 16'h0002);

    for (int i = 0; i < 8; i++) wr(16'hFFF0, 16'h0010 + 16'(i));
    cyc(16'hFFF0, 16'h0077, 1'b1, 1'b1, 1'b0, 8'h00);
    rd(16'hFFF1);
    chk("full_push_pop_status", obsRead, 16'h0008);
    n = 0;
    lastByte = 8'h00;
    for (int i = 0; i < 12; i++) begin
      cyc(16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 8'h00);
      if (obsTxValid) begin n++; lastByte = obsTxData; end
    end
    chk("full_push_pop_count", 16'(n), 16'd7);
    chk("full_push_dropped", {8'h00, lastByte}, 16'h0017);
    wr(16'hFFF1, 16'h0008);

    cyc(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 8'h5A);
    chk("rx_ready_idle", {15'b0, obsRxReady}, 16'h0001);
    rd(16'hFFF2);
    chk("rx_ready_held", {15'b0, obsRxReady}, 16'h0000);
    chk("rx_data", obsRead, 16'h005A);
    cyc(16'hFFF2, 16'h0000, 1'b1, 1'b0, 1'b1, 8'hA5);
    cyc(16'hFFF2, 16'h0000, 1'b0, 1'b0, 1'b1, 8'hA5);
    chk("rx_clear_ready", {15'b0, obsRxReady}, 16'h0001);
    chk("rx_not_yet", obsRead, 16'h005A);
    rd(16'hFFF2);
    chk("rx_second", obsRead, 16'h00A5);

    repeat (255) cyc(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 8'h00);
    cyc(16'hFFF1, 16'h0000, 1'b0, 1'b0, 1'b1, 8'h00);
    chk("stall_255", obsRead, 16'h0006);
    rd(16'hFFF1);
    chk("stall_256", obsRead, 16'h0016);
    wr(16'hFFF1, 16'h0010);
    rd(16'hFFF1);
    chk("rxovr_cleared", obsRead, 16'h0006);

    wr(16'hFFF3, 16'hFFFE);
    for (int i = 0; i <= 8; i++) begin
      rd(16'hFFF3);
      if (i == 3) chk("timer_3", obsRead, 16'hFFFE);
      if (i == 4) chk("timer_4", obsRead, 16'hFFFF);
      if (i == 8) chk("timer_wrap", obsRead, 16'h0000);
    end

    wr(16'hFFF0, 16'h0033);
    rst = 0;
    cyc(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h00);
    rst = 1;
    rd(16'hFFF3);
    chk("rst_timer", obsRead, 16'h0000);
    chk("rst_txvalid", {15'b0, obsTxValid}, 16'h0000);
    rd(16'hFFF1);
    chk("rst_status", obsRead, 16'h0002);

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) < 7) ra = {12'hFFF, 4'($urandom_range(0, 5))};
      else ra = 16'($urandom_range(0, 16'hFFEF));
      rst = ($urandom_range(0, 99) != 0);
      cyc(ra, 16'($urandom), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 2) != 0), 8'($urandom));
    end
    rst = 1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
